// File: rtl/counter_wrap_monitor.sv
// Wrap-event monitor for an upstream counter stage.
// Counts all-ones -> zero transitions of cnt_in into a saturating accumulator.
// Raises a level interrupt when a programmable threshold is reached.
// Keeps a sticky flag for rising edges of the upstream overflow output.
module counter_wrap_monitor #(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              ovf_in,
  input  logic              arm,
  input  logic [WRAP_W-1:0] threshold,
  input  logic              irq_ack,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              irq,
  output logic              saturated,
  output logic              ovf_seen,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StCounting = 2'd1,
    StPending  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  prev_cnt_q;
  logic              prev_valid_q;
  logic              prev_ovf_q;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;
  logic [WRAP_W-1:0] wrap_inc;
  logic              saturated_q, saturated_d;
  logic              ovf_seen_q, ovf_seen_d;
  logic              irq_q;
  logic              wrap_event;
  logic              ovf_rise;
  logic              thresh_hit;

  localparam logic [WRAP_W-1:0] WrapMax = {WRAP_W{1'b1}};
  localparam logic [WRAP_W-1:0] WrapOne = {{(WRAP_W-1){1'b0}}, 1'b1};

  // A wrap is a step from all-ones to zero between two valid samples.
  assign wrap_event = prev_valid_q && (prev_cnt_q == {CNT_W{1'b1}}) && (cnt_in == '0);
  assign ovf_rise   = ovf_in && !prev_ovf_q;
  // Saturating increment: holds at all-ones instead of rolling over.
  assign wrap_inc   = (wrap_count_q == WrapMax) ? wrap_count_q : wrap_count_q + WrapOne;
  // threshold of zero disables the interrupt entirely.
  assign thresh_hit = wrap_event && (threshold != '0) && (wrap_inc == threshold);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; de-arm wins over a threshold hit while counting.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (arm) state_d = StCounting;
      end
      StCounting: begin
        if (!arm) begin
          state_d = StIdle;
        end else if (thresh_hit) begin
          state_d = StPending;
        end
      end
      StPending: begin
        if (irq_ack) state_d = arm ? StCounting : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Accumulator and sticky-flag next values.
  always_comb begin
    wrap_count_d = wrap_count_q;
    saturated_d  = saturated_q;
    ovf_seen_d   = ovf_seen_q;
    unique case (state_q)
      StIdle: begin
        // Entering COUNTING starts a fresh measurement window.
        if (arm) begin
          wrap_count_d = '0;
          saturated_d  = 1'b0;
          ovf_seen_d   = 1'b0;
        end
      end
      StCounting: begin
        if (arm && wrap_event) begin
          wrap_count_d = wrap_inc;
          if (wrap_inc == WrapMax) saturated_d = 1'b1;
        end
      end
      StPending: begin
        if (irq_ack) begin
          // A wrap coinciding with the ack is the first event of the new window.
          wrap_count_d = wrap_event ? WrapOne : '0;
        end else if (wrap_event) begin
          wrap_count_d = wrap_inc;
          if (wrap_inc == WrapMax) saturated_d = 1'b1;
        end
      end
      default: ;
    endcase
    if ((state_q != StIdle) && ovf_rise) ovf_seen_d = 1'b1;
  end

  // Datapath registers; irq tracks the registered PENDING state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_count_q <= '0;
      saturated_q  <= 1'b0;
      ovf_seen_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      wrap_count_q <= wrap_count_d;
      saturated_q  <= saturated_d;
      ovf_seen_q   <= ovf_seen_d;
      irq_q        <= (state_d == StPending);
    end
  end

  // Previous-sample history, updated every cycle regardless of state.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_cnt_q   <= '0;
      prev_valid_q <= 1'b0;
      prev_ovf_q   <= 1'b0;
    end else begin
      prev_cnt_q   <= cnt_in;
      prev_valid_q <= 1'b1;
      prev_ovf_q   <= ovf_in;
    end
  end

  // Output drive.
  always_comb begin
    wrap_count = wrap_count_q;
    irq        = irq_q;
    saturated  = saturated_q;
    ovf_seen   = ovf_seen_q;
    state      = state_q;
  end

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Self-checking bench for counter_wrap_monitor: directed vector table, hand-written
// corner sequences and a randomized run, all compared against a behavioural model.
module tb_counter_wrap_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_in;
  logic       ovf_in;
  logic       arm;
  logic [7:0] threshold;
  logic       irq_ack;
  logic [7:0] wrap_count;
  logic       irq;
  logic       saturated;
  logic       ovf_seen;
  logic [1:0] state;

  counter_wrap_monitor #(
    .CNT_W (4),
    .WRAP_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cnt_in    (cnt_in),
    .ovf_in    (ovf_in),
    .arm       (arm),
    .threshold (threshold),
    .irq_ack   (irq_ack),
    .wrap_count(wrap_count),
    .irq       (irq),
    .saturated (saturated),
    .ovf_seen  (ovf_seen),
    .state     (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 idle, 1 counting, 2 pending; plain integers throughout.
  int m_mode, m_count, m_prev;
  bit m_irq, m_sat, m_ovf, m_have_prev, m_prev_ovf;

  function automatic void model_reset();
    m_mode = 0; m_count = 0; m_prev = 0;
    m_irq = 0; m_sat = 0; m_ovf = 0; m_have_prev = 0; m_prev_ovf = 0;
  endfunction

  function automatic void model_bump();
    if (m_count < 255) m_count = m_count + 1;
    if (m_count == 255) m_sat = 1;
  endfunction

  function automatic void model_step(bit r, int c, bit o, bit a, int t, bit k);
    bit wrapped;
    bit rose;
    int was;
    if (r) begin
      model_reset();
      return;
    end
    wrapped = m_have_prev && (m_prev == 15) && (c == 0);
    rose    = o && !m_prev_ovf;
    was     = m_mode;
    if (was == 0) begin
      if (a) begin
        m_mode = 1; m_count = 0; m_sat = 0; m_ovf = 0;
      end
    end else if (was == 1) begin
      if (!a) begin
        m_mode = 0;
      end else if (wrapped) begin
        model_bump();
        if (t != 0 && m_count == t) m_mode = 2;
      end
    end else begin
      if (k) begin
        m_count = wrapped ? 1 : 0;
        m_mode  = a ? 1 : 0;
      end else if (wrapped) begin
        model_bump();
      end
    end
    if (was != 0 && rose) m_ovf = 1;
    m_prev = c; m_prev_ovf = o; m_have_prev = 1;
    m_irq = (m_mode == 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, sample #1 after the edge and compare.
  task automatic step(input bit r, input int c, input bit o, input bit a, input bit k);
    reset = r; cnt_in = c[3:0]; ovf_in = o; arm = a; irq_ack = k;
    model_step(r, c, o, a, int'(threshold), k);
    @(posedge clk);
    #1;
    chk("model_wrap_count", 32'(wrap_count), 32'(m_count));
    chk("model_state", 32'(state), 32'(m_mode));
    chk("model_irq", 32'(irq), 32'(m_irq));
    chk("model_saturated", 32'(saturated), 32'(m_sat));
    chk("model_ovf_seen", 32'(ovf_seen), 32'(m_ovf));
  endtask

  task automatic sweep(input int from, input bit a, input bit k);
    for (int v = from; v < 16; v++) step(1'b0, v, 1'b0, a, k);
  endtask

  typedef struct {
    bit rst; int cnt; bit ovf; bit arm; int thr; bit ack;
    int e_wc; int e_st; bit e_irq; bit e_sat; bit e_ovf;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int c;
    bit a;
    model_reset();
    reset = 1'b1; cnt_in = '0; ovf_in = 1'b0; arm = 1'b0; threshold = '0; irq_ack = 1'b0;

    // rst cnt ovf arm thr ack | wc st irq sat ovf
    vecs[0]  = '{1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0}; // 15->0 across reset is not a wrap
    vecs[2]  = '{0, 14, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[3]  = '{0,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0}; // 14->0
    vecs[4]  = '{0, 15, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[5]  = '{0, 15, 0, 1, 0, 0, 0, 1, 0, 0, 0}; // hold at 15
    vecs[6]  = '{0,  3, 0, 1, 0, 0, 0, 1, 0, 0, 0}; // 15->3
    vecs[7]  = '{0, 15, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[8]  = '{0,  0, 0, 1, 0, 0, 1, 1, 0, 0, 0}; // real wrap
    vecs[9]  = '{0, 15, 0, 1, 2, 0, 1, 1, 0, 0, 0};
    vecs[10] = '{0,  0, 0, 1, 2, 0, 2, 2, 1, 0, 0}; // threshold reached
    vecs[11] = '{0, 15, 0, 1, 2, 0, 2, 2, 1, 0, 0};
    vecs[12] = '{0,  0, 0, 1, 2, 1, 1, 1, 0, 0, 0}; // ack with coincident wrap
    vecs[13] = '{0,  1, 1, 1, 2, 0, 1, 1, 0, 0, 1}; // ovf rise while armed
    vecs[14] = '{0,  2, 0, 1, 2, 0, 1, 1, 0, 0, 1};
    vecs[15] = '{0,  3, 0, 0, 2, 0, 1, 0, 0, 0, 1}; // de-arm holds count

    for (int i = 0; i < 16; i++) begin
      threshold = vecs[i].thr[7:0];
      step(vecs[i].rst, vecs[i].cnt, vecs[i].ovf, vecs[i].arm, vecs[i].ack);
      chk("vec_wrap_count", 32'(wrap_count), 32'(vecs[i].e_wc));
      chk("vec_state", 32'(state), 32'(vecs[i].e_st));
      chk("vec_irq", 32'(irq), 32'(vecs[i].e_irq));
      chk("vec_saturated", 32'(saturated), 32'(vecs[i].e_sat));
      chk("vec_ovf_seen", 32'(ovf_seen), 32'(vecs[i].e_ovf));
    end

    // Threshold 3 with sweeps, then hold pending through two more wraps, then ack.
    threshold = 8'd3;
    step(1'b1, 0, 1'b0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) sweep(0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("t1_wrap_count", 32'(wrap_count), 32'd3);
    chk("t1_state", 32'(state), 32'd2);
    chk("t1_irq", 32'(irq), 32'd1);
    for (int r = 0; r < 2; r++) begin
      sweep(1, 1'b1, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    end
    chk("t2_wrap_count", 32'(wrap_count), 32'd5);
    chk("t2_irq", 32'(irq), 32'd1);
    step(1'b0, 1, 1'b0, 1'b1, 1'b1);
    chk("t2_ack_count", 32'(wrap_count), 32'd0);
    chk("t2_ack_state", 32'(state), 32'd1);
    chk("t2_ack_irq", 32'(irq), 32'd0);

    // Threshold disabled: 300 wraps saturate at 255, then re-arm clears.
    threshold = 8'd0;
    step(1'b1, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int r = 0; r < 300; r++) begin
      sweep(1, 1'b1, 1'b0);
      step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    end
    chk("t4_wrap_count", 32'(wrap_count), 32'd255);
    chk("t4_saturated", 32'(saturated), 32'd1);
    chk("t4_irq", 32'(irq), 32'd0);
    step(1'b0, 1, 1'b0, 1'b0, 1'b0);
    chk("t4_idle_hold", 32'(wrap_count), 32'd255);
    step(1'b0, 2, 1'b0, 1'b1, 1'b0);
    chk("t4_rearm_count", 32'(wrap_count), 32'd0);
    chk("t4_rearm_sat", 32'(saturated), 32'd0);

    // Overflow pulse ignored in IDLE, captured when armed; reset drops PENDING.
    step(1'b1, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("t6_idle_ovf", 32'(ovf_seen), 32'd0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1, 1'b1, 1'b1, 1'b0);
    chk("t6_armed_ovf", 32'(ovf_seen), 32'd1);
    step(1'b0, 2, 1'b0, 1'b1, 1'b0);
    chk("t6_ovf_sticky", 32'(ovf_seen), 32'd1);
    threshold = 8'd1;
    sweep(3, 1'b1, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    chk("t6_pending_irq", 32'(irq), 32'd1);
    step(1'b1, 1, 1'b0, 1'b1, 1'b0);
    chk("t6_reset_irq", 32'(irq), 32'd0);
    chk("t6_reset_state", 32'(state), 32'd0);
    chk("t6_reset_count", 32'(wrap_count), 32'd0);
    chk("t6_reset_ovf", 32'(ovf_seen), 32'd0);

    // Randomized run: mostly incrementing count with jumps, arm/ack/ovf/threshold churn.
    c = 0;
    a = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : (c + 1) % 16;
      if ($urandom_range(0, 39) == 0) a = ~a;
      if ($urandom_range(0, 99) == 0) threshold = 8'($urandom_range(0, 6));
      step($urandom_range(0, 299) == 0, c, $urandom_range(0, 7) == 0, a,
           $urandom_range(0, 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
